reservation_station: RTL and testbench

Out-of-order issue buffer that feeds the ALU in the Tomasulo core. Holds dispatched integer/branch/jump/U-type instructions until both source operands are available, capturing values from the ALU and LSB result broadcasts. Each cycle it issues the lowest-index ready entry to the ALU using the `rs_*` bus. It also frees entries and reports full status to dispatch.

---
 rtl/reservation_station_pkg.sv | 49 ++++
 rtl/reservation_station_rs_select.sv | 26 ++
 rtl/reservation_station.sv | 167 ++++++++++++++++
 tb/tb_reservation_station.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station slice.
//   - ROB tag width and operand/word widths
//   - operation encodings used by dispatch and the ALU
//   - rs_data_t: per-entry payload (everything except the control bits)
//   - fwd_value: picks a broadcast value for an operand, ALU taking priority
package reservation_station_pkg;

  localparam int ENTRY_W = 4;   // ROB tag width
  localparam int DATA_W  = 32;
  localparam int OP_W    = 6;

  localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd17;
  localparam logic [OP_W-1:0] OP_SLLI  = 6'd23;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd26;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd27;
  localparam logic [OP_W-1:0] OP_AND   = 6'd35;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [DATA_W-1:0]  instruction;
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  imm;
    logic [ENTRY_W-1:0] qj;
    logic [ENTRY_W-1:0] qk;
    logic [DATA_W-1:0]  vj;
    logic [DATA_W-1:0]  vk;
    logic [ENTRY_W-1:0] des;
  } rs_data_t;

  // ALU wins if both broadcasts carry the same tag in one cycle.
  function automatic logic [DATA_W-1:0] fwd_value(
    input logic              alu_hit,
    input logic              lsb_hit,
    input logic [DATA_W-1:0] alu_v,
    input logic [DATA_W-1:0] lsb_v,
    input logic [DATA_W-1:0] own_v
  );
    if (alu_hit)      return alu_v;
    else if (lsb_hit) return lsb_v;
    else              return own_v;
  endfunction

endpackage

// File: rtl/reservation_station_rs_select.sv
// rs_select: lowest-index priority encoder.
//   req   - request bit vector
//   idx   - index of the lowest set bit (0 when none)
//   found - at least one bit of req is set
module rs_select #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// reservation_station: out-of-order issue buffer in front of the ALU.
//   clk_in, rst_in (async active-low), rdy_in (global stall), clear (flush)
//   dsp_*          - dispatch request with operands / producer tags
//   rs_full        - every entry busy (combinational)
//   alu_*, lsb_*   - result broadcasts used for wakeup and forwarding
//   rs_*           - registered issue payload, rs_new_calculate strobes it
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX_W = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear,
  input  logic               dsp_valid,
  input  logic [OP_W-1:0]    dsp_op,
  input  logic [DATA_W-1:0]  dsp_instruction,
  input  logic [DATA_W-1:0]  dsp_pc,
  input  logic [DATA_W-1:0]  dsp_imm,
  input  logic               dsp_qj_busy,
  input  logic               dsp_qk_busy,
  input  logic [ENTRY_W-1:0] dsp_qj,
  input  logic [ENTRY_W-1:0] dsp_qk,
  input  logic [DATA_W-1:0]  dsp_vj,
  input  logic [DATA_W-1:0]  dsp_vk,
  input  logic [ENTRY_W-1:0] dsp_des,
  output logic               rs_full,
  input  logic               alu_broadcast,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [ENTRY_W-1:0] alu_entry,
  input  logic               lsb_broadcast,
  input  logic [DATA_W-1:0]  lsb_result,
  input  logic [ENTRY_W-1:0] lsb_entry,
  output logic               rs_new_calculate,
  output logic [OP_W-1:0]    rs_op,
  output logic [DATA_W-1:0]  rs_instruction,
  output logic [DATA_W-1:0]  rs_vj,
  output logic [DATA_W-1:0]  rs_vk,
  output logic [DATA_W-1:0]  rs_pc,
  output logic [DATA_W-1:0]  rs_imm,
  output logic [ENTRY_W-1:0] rs_des
);

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qj_busy;
  logic [RS_SIZE-1:0] qk_busy;
  rs_data_t           ent [RS_SIZE];

  logic [RS_SIZE-1:0] wj_alu, wj_lsb, wk_alu, wk_lsb;
  logic [RS_SIZE-1:0] ready;

  logic [RS_IDX_W-1:0] ready_idx, free_idx;
  logic                ready_found, free_found;

  logic              fj_alu, fj_lsb, fk_alu, fk_lsb;
  logic              dsp_accept;
  logic              dsp_qj_pend, dsp_qk_pend;
  logic [DATA_W-1:0] dsp_vj_fwd, dsp_vk_fwd;

  assign rs_full = &busy;

  // Per-entry wakeup comparators against both broadcast buses.
  always_comb begin
    wj_alu = '0;
    wj_lsb = '0;
    wk_alu = '0;
    wk_lsb = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      wj_alu[i] = busy[i] && qj_busy[i] && alu_broadcast && (ent[i].qj == alu_entry);
      wj_lsb[i] = busy[i] && qj_busy[i] && lsb_broadcast && (ent[i].qj == lsb_entry);
      wk_alu[i] = busy[i] && qk_busy[i] && alu_broadcast && (ent[i].qk == alu_entry);
      wk_lsb[i] = busy[i] && qk_busy[i] && lsb_broadcast && (ent[i].qk == lsb_entry);
    end
  end

  // Readiness uses stored state only, so a wakeup takes effect one edge later.
  assign ready = busy & ~qj_busy & ~qk_busy;

  rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_ready_sel (
    .req   (ready),
    .idx   (ready_idx),
    .found (ready_found)
  );

  rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_sel (
    .req   (~busy),
    .idx   (free_idx),
    .found (free_found)
  );

  // Same-cycle forwarding for an incoming dispatch.
  assign fj_alu = dsp_qj_busy && alu_broadcast && (dsp_qj == alu_entry);
  assign fj_lsb = dsp_qj_busy && lsb_broadcast && (dsp_qj == lsb_entry);
  assign fk_alu = dsp_qk_busy && alu_broadcast && (dsp_qk == alu_entry);
  assign fk_lsb = dsp_qk_busy && lsb_broadcast && (dsp_qk == lsb_entry);

  assign dsp_qj_pend = dsp_qj_busy && !fj_alu && !fj_lsb;
  assign dsp_qk_pend = dsp_qk_busy && !fk_alu && !fk_lsb;
  assign dsp_vj_fwd  = fwd_value(fj_alu, fj_lsb, alu_result, lsb_result, dsp_vj);
  assign dsp_vk_fwd  = fwd_value(fk_alu, fk_lsb, alu_result, lsb_result, dsp_vk);

  // rs_full is sampled before any issue this cycle, so a slot freed by the
  // same edge cannot be claimed until the next cycle.
  assign dsp_accept = dsp_valid && !rs_full && free_found && rdy_in && !clear;

  // Control state and issue outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy             <= '0;
      qj_busy          <= '0;
      qk_busy          <= '0;
      rs_new_calculate <= 1'b0;
      rs_op            <= '0;
      rs_instruction   <= '0;
      rs_vj            <= '0;
      rs_vk            <= '0;
      rs_pc            <= '0;
      rs_imm           <= '0;
      rs_des           <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        busy             <= '0;
        rs_new_calculate <= 1'b0;
      end else begin
        qj_busy          <= qj_busy & ~(wj_alu | wj_lsb);
        qk_busy          <= qk_busy & ~(wk_alu | wk_lsb);
        rs_new_calculate <= ready_found;
        if (ready_found) begin
          busy[ready_idx] <= 1'b0;
          rs_op           <= ent[ready_idx].op;
          rs_instruction  <= ent[ready_idx].instruction;
          rs_vj           <= ent[ready_idx].vj;
          rs_vk           <= ent[ready_idx].vk;
          rs_pc           <= ent[ready_idx].pc;
          rs_imm          <= ent[ready_idx].imm;
          rs_des          <= ent[ready_idx].des;
        end
        // The free slot is never the issuing slot (one is busy, one is not).
        if (dsp_accept) begin
          busy[free_idx]    <= 1'b1;
          qj_busy[free_idx] <= dsp_qj_pend;
          qk_busy[free_idx] <= dsp_qk_pend;
        end
      end
    end
  end

  // Entry payload storage; meaningful only while the matching busy bit is set.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (wj_alu[i] || wj_lsb[i])
          ent[i].vj <= fwd_value(wj_alu[i], wj_lsb[i], alu_result, lsb_result, ent[i].vj);
        if (wk_alu[i] || wk_lsb[i])
          ent[i].vk <= fwd_value(wk_alu[i], wk_lsb[i], alu_result, lsb_result, ent[i].vk);
      end
      if (dsp_accept) begin
        ent[free_idx] <= '{op: dsp_op, instruction: dsp_instruction, pc: dsp_pc,
                           imm: dsp_imm, qj: dsp_qj, qk: dsp_qk,
                           vj: dsp_vj_fwd, vk: dsp_vk_fwd, des: dsp_des};
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               rdy_in;
  logic               clear;
  logic               dsp_valid;
  logic [OP_W-1:0]    dsp_op;
  logic [DATA_W-1:0]  dsp_instruction, dsp_pc, dsp_imm;
  logic               dsp_qj_busy, dsp_qk_busy;
  logic [ENTRY_W-1:0] dsp_qj, dsp_qk, dsp_des;
  logic [DATA_W-1:0]  dsp_vj, dsp_vk;
  logic               rs_full;
  logic               alu_broadcast, lsb_broadcast;
  logic [DATA_W-1:0]  alu_result, lsb_result;
  logic [ENTRY_W-1:0] alu_entry, lsb_entry;
  logic               rs_new_calculate;
  logic [OP_W-1:0]    rs_op;
  logic [DATA_W-1:0]  rs_instruction, rs_vj, rs_vk, rs_pc, rs_imm;
  logic [ENTRY_W-1:0] rs_des;

  int checks   = 0;
  int failures = 0;

  reservation_station #(.RS_SIZE(16), .RS_IDX_W(4)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .clear            (clear),
    .dsp_valid        (dsp_valid),
    .dsp_op           (dsp_op),
    .dsp_instruction  (dsp_instruction),
    .dsp_pc           (dsp_pc),
    .dsp_imm          (dsp_imm),
    .dsp_qj_busy      (dsp_qj_busy),
    .dsp_qk_busy      (dsp_qk_busy),
    .dsp_qj           (dsp_qj),
    .dsp_qk           (dsp_qk),
    .dsp_vj           (dsp_vj),
    .dsp_vk           (dsp_vk),
    .dsp_des          (dsp_des),
    .rs_full          (rs_full),
    .alu_broadcast    (alu_broadcast),
    .alu_result       (alu_result),
    .alu_entry        (alu_entry),
    .lsb_broadcast    (lsb_broadcast),
    .lsb_result       (lsb_result),
    .lsb_entry        (lsb_entry),
    .rs_new_calculate (rs_new_calculate),
    .rs_op            (rs_op),
    .rs_instruction   (rs_instruction),
    .rs_vj            (rs_vj),
    .rs_vk            (rs_vk),
    .rs_pc            (rs_pc),
    .rs_imm           (rs_imm),
    .rs_des           (rs_des)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_dsp(input logic [OP_W-1:0] op,
                           input logic qjb, input logic [ENTRY_W-1:0] qj, input logic [31:0] vj,
                           input logic qkb, input logic [ENTRY_W-1:0] qk, input logic [31:0] vk,
                           input logic [ENTRY_W-1:0] des);
    dsp_valid       = 1'b1;
    dsp_op          = op;
    dsp_instruction = 32'h0000_0033 | (32'(des) << 7);
    dsp_pc          = 32'h0000_1000 + 32'(des);
    dsp_imm         = 32'hFFFF_FF00 | 32'(des);
    dsp_qj_busy     = qjb;
    dsp_qj          = qj;
    dsp_vj          = vj;
    dsp_qk_busy     = qkb;
    dsp_qk          = qk;
    dsp_vk          = vk;
    dsp_des         = des;
  endtask

  task automatic alu_bc(input logic [ENTRY_W-1:0] e, input logic [31:0] v);
    alu_broadcast = 1'b1; alu_entry = e; alu_result = v;
  endtask

  task automatic lsb_bc(input logic [ENTRY_W-1:0] e, input logic [31:0] v);
    lsb_broadcast = 1'b1; lsb_entry = e; lsb_result = v;
  endtask

  task automatic quiet();
    dsp_valid = 1'b0; alu_broadcast = 1'b0; lsb_broadcast = 1'b0; clear = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    dsp_valid = 1'b0; dsp_op = '0; dsp_instruction = '0; dsp_pc = '0; dsp_imm = '0;
    dsp_qj_busy = 1'b0; dsp_qk_busy = 1'b0; dsp_qj = '0; dsp_qk = '0;
    dsp_vj = '0; dsp_vk = '0; dsp_des = '0;
    alu_broadcast = 1'b0; alu_result = '0; alu_entry = '0;
    lsb_broadcast = 1'b0; lsb_result = '0; lsb_entry = '0;

    // Reset state
    step(); step();
    chk("reset_full", 32'(rs_full), 0);
    chk("reset_newcalc", 32'(rs_new_calculate), 0);
    chk("reset_vj", rs_vj, 0);
    chk("reset_des", 32'(rs_des), 0);
    rst_in = 1'b1;
    step();

    // ADD with both operands ready
    drive_dsp(OP_ADD, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd3);
    step(); quiet();
    chk("add_not_yet", 32'(rs_new_calculate), 0);
    step();
    chk("add_newcalc", 32'(rs_new_calculate), 1);
    chk("add_vj", rs_vj, 32'd5);
    chk("add_vk", rs_vk, 32'd7);
    chk("add_des", 32'(rs_des), 3);
    chk("add_op", 32'(rs_op), 32'(OP_ADD));
    chk("add_pc", rs_pc, 32'h0000_1003);
    step();
    chk("idle_newcalc", 32'(rs_new_calculate), 0);
    chk("idle_vj_hold", rs_vj, 32'd5);

    // SUB waiting on tag 9, woken by ALU broadcast
    drive_dsp(OP_SUB, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd1, 4'd4);
    step(); quiet();
    step(); step();
    chk("sub_waiting", 32'(rs_new_calculate), 0);
    alu_bc(4'd9, 32'h20);
    step(); quiet();
    chk("sub_wake_edge", 32'(rs_new_calculate), 0);
    step();
    chk("sub_newcalc", 32'(rs_new_calculate), 1);
    chk("sub_vj", rs_vj, 32'h20);
    chk("sub_vk", rs_vk, 32'd1);
    chk("sub_des", 32'(rs_des), 4);

    // Same-cycle forwarding from LSB at dispatch
    drive_dsp(OP_AND, 1'b0, 4'd0, 32'h11, 1'b1, 4'd2, 32'd0, 4'd6);
    lsb_bc(4'd2, 32'hFFFF);
    step(); quiet();
    step();
    chk("fwd_newcalc", 32'(rs_new_calculate), 1);
    chk("fwd_vk", rs_vk, 32'hFFFF);
    chk("fwd_des", 32'(rs_des), 6);

    // ALU beats LSB on an identical tag: dispatch forward, then wakeup
    drive_dsp(OP_ADD, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd0, 4'd7);
    alu_bc(4'd6, 32'hA1); lsb_bc(4'd6, 32'hB2);
    step(); quiet();
    step();
    chk("prio_fwd_vj", rs_vj, 32'hA1);
    drive_dsp(OP_ADD, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'd0, 4'd8);
    step(); quiet();
    alu_bc(4'd6, 32'hC3); lsb_bc(4'd6, 32'hD4);
    step(); quiet();
    step();
    chk("prio_wake_vk", rs_vk, 32'hC3);
    chk("prio_wake_des", 32'(rs_des), 8);

    // Fill all 16 entries with pending operands (qj tag = des = i)
    for (int i = 0; i < 16; i++) begin
      drive_dsp(OP_ADDI, 1'b1, 4'(i), 32'd0, 1'b0, 4'd0, 32'd0, 4'(i));
      step();
    end
    quiet();
    chk("fill_full", 32'(rs_full), 1);
    chk("fill_no_issue", 32'(rs_new_calculate), 0);
    // 17th dispatch is ready-to-go; it must be ignored
    drive_dsp(OP_LUI, 1'b0, 4'd0, 32'hEE, 1'b0, 4'd0, 32'd0, 4'd15);
    step(); quiet();
    step();
    chk("full_reject_newcalc", 32'(rs_new_calculate), 0);
    chk("full_still", 32'(rs_full), 1);
    alu_bc(4'd5, 32'h55);
    step(); quiet();
    chk("full_after_wake", 32'(rs_full), 1);
    // Dispatch during the issuing cycle: still full, so rejected
    drive_dsp(OP_LUI, 1'b0, 4'd0, 32'hEE, 1'b0, 4'd0, 32'd0, 4'd14);
    step(); quiet();
    chk("full_issue_newcalc", 32'(rs_new_calculate), 1);
    chk("full_issue_des", 32'(rs_des), 5);
    chk("full_issue_vj", rs_vj, 32'h55);
    chk("full_released", 32'(rs_full), 0);
    clear = 1'b1;
    step(); quiet();
    chk("clear_full", 32'(rs_full), 0);

    // Entries 3 and 7 wake together
    for (int i = 0; i < 8; i++) begin
      drive_dsp(OP_ADD, 1'b1, (i == 3 || i == 7) ? 4'd12 : 4'd13, 32'd0,
                1'b0, 4'd0, 32'd1, 4'(i));
      step();
    end
    quiet();
    alu_bc(4'd12, 32'h77);
    step(); quiet();
    chk("pair_wake_edge", 32'(rs_new_calculate), 0);
    step();
    chk("pair_first_des", 32'(rs_des), 3);
    chk("pair_first_vj", rs_vj, 32'h77);
    step();
    chk("pair_second_des", 32'(rs_des), 7);
    chk("pair_second_newcalc", 32'(rs_new_calculate), 1);
    step();
    chk("pair_done", 32'(rs_new_calculate), 0);
    clear = 1'b1;
    step(); quiet();

    // Clear with 5 busy entries and a concurrent dispatch
    for (int i = 0; i < 5; i++) begin
      drive_dsp(OP_ADD, 1'b1, 4'd11, 32'd0, 1'b0, 4'd0, 32'd0, 4'(i));
      step();
    end
    quiet();
    clear = 1'b1;
    drive_dsp(OP_ADD, 1'b0, 4'd0, 32'h99, 1'b0, 4'd0, 32'd0, 4'd9);
    step(); quiet();
    chk("clr_newcalc", 32'(rs_new_calculate), 0);
    alu_bc(4'd11, 32'h1);
    step(); quiet();
    chk("clr_dropped", 32'(rs_new_calculate), 0);
    step();
    chk("clr_entries_gone", 32'(rs_new_calculate), 0);

    // rdy_in low freezes everything
    drive_dsp(OP_ADD, 1'b0, 4'd0, 32'hAB, 1'b0, 4'd0, 32'd0, 4'd8);
    step();
    drive_dsp(OP_ADD, 1'b0, 4'd0, 32'hCD, 1'b0, 4'd0, 32'd0, 4'd10);
    step(); quiet();
    chk("rdy_issue_a", 32'(rs_des), 8);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rdy_hold_newcalc", 32'(rs_new_calculate), 1);
      chk("rdy_hold_vj", rs_vj, 32'hAB);
    end
    rdy_in = 1'b1;
    drive_dsp(OP_ADD, 1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 32'd0, 4'd2);
    step(); quiet();
    chk("rdy_issue_b", 32'(rs_des), 10);
    chk("rdy_issue_b_newcalc", 32'(rs_new_calculate), 1);

    // Asynchronous reset mid-operation
    #1 rst_in = 1'b0;
    #2;
    chk("async_newcalc", 32'(rs_new_calculate), 0);
    chk("async_vj", rs_vj, 0);
    chk("async_des", 32'(rs_des), 0);
    rst_in = 1'b1;
    alu_bc(4'd1, 32'h5);
    step(); quiet();
    step();
    chk("async_entry_gone", 32'(rs_new_calculate), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
